// File: rtl/frv_asi_arb_if.sv
// Bundle of the two requester ports and the shared ASI unit port of frv_asi_arb.
// The slave modport is the arbiter's view; master is the surrounding requesters/ASI unit.
interface frv_asi_arb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned UOP_W = 7
);
    // Requester 0 (core execute stage)
    logic             req0_valid;
    logic [UOP_W-1:0] req0_uop;
    logic [XLEN-1:0]  req0_rs1;
    logic [XLEN-1:0]  req0_rs2;
    logic [1:0]       req0_shamt;
    logic             req0_ready;
    logic [XLEN-1:0]  req0_result;
    logic             req0_error;

    // Requester 1 (crypto co-master)
    logic             req1_valid;
    logic [UOP_W-1:0] req1_uop;
    logic [XLEN-1:0]  req1_rs1;
    logic [XLEN-1:0]  req1_rs2;
    logic [1:0]       req1_shamt;
    logic             req1_ready;
    logic [XLEN-1:0]  req1_result;
    logic             req1_error;

    // Shared ASI unit
    logic             asi_valid;
    logic [UOP_W-1:0] asi_uop;
    logic [XLEN-1:0]  asi_rs1;
    logic [XLEN-1:0]  asi_rs2;
    logic [1:0]       asi_shamt;
    logic             asi_ready;
    logic [XLEN-1:0]  asi_result;
    logic             asi_flush;

    modport slave (
        input  req0_valid, req0_uop, req0_rs1, req0_rs2, req0_shamt,
        output req0_ready, req0_result, req0_error,
        input  req1_valid, req1_uop, req1_rs1, req1_rs2, req1_shamt,
        output req1_ready, req1_result, req1_error,
        output asi_valid, asi_uop, asi_rs1, asi_rs2, asi_shamt, asi_flush,
        input  asi_ready, asi_result
    );

    modport master (
        output req0_valid, req0_uop, req0_rs1, req0_rs2, req0_shamt,
        input  req0_ready, req0_result, req0_error,
        output req1_valid, req1_uop, req1_rs1, req1_rs2, req1_shamt,
        input  req1_ready, req1_result, req1_error,
        input  asi_valid, asi_uop, asi_rs1, asi_rs2, asi_shamt, asi_flush,
        output asi_ready, asi_result
    );
endinterface

// File: rtl/frv_asi_arb.sv
// Round-robin arbiter/sequencer sharing one ASI (AES/SHA2/SHA3) unit between two requesters,
// with registered operands, registered per-requester results and a BUSY watchdog.
module frv_asi_arb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned UOP_W   = 7,
    parameter int unsigned TIMEOUT = 15
) (
    input logic           g_clk,
    input logic           g_reset,
    frv_asi_arb_if.slave  bus
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

    state_t           state_q;
    logic             owner_q;
    logic             last_q;
    logic [CntW-1:0]  wd_cnt_q;

    logic             asi_valid_q;
    logic [UOP_W-1:0] asi_uop_q;
    logic [XLEN-1:0]  asi_rs1_q;
    logic [XLEN-1:0]  asi_rs2_q;
    logic [1:0]       asi_shamt_q;
    logic             asi_flush_q;

    logic             rdy0_q, rdy1_q;
    logic             err0_q, err1_q;
    logic [XLEN-1:0]  res0_q, res1_q;

    logic             gnt_any;
    logic             gnt_sel;
    logic [UOP_W-1:0] gnt_uop;
    logic [XLEN-1:0]  gnt_rs1;
    logic [XLEN-1:0]  gnt_rs2;
    logic [1:0]       gnt_shamt;
    logic             wd_fire;

    // On contention grant the requester that was not served last.
    always_comb begin
        gnt_any = bus.req0_valid | bus.req1_valid;
        gnt_sel = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
        if (gnt_sel) begin
            gnt_uop   = bus.req1_uop;
            gnt_rs1   = bus.req1_rs1;
            gnt_rs2   = bus.req1_rs2;
            gnt_shamt = bus.req1_shamt;
        end else begin
            gnt_uop   = bus.req0_uop;
            gnt_rs1   = bus.req0_rs1;
            gnt_rs2   = bus.req0_rs2;
            gnt_shamt = bus.req0_shamt;
        end
    end

    assign wd_fire = (TIMEOUT != 0) && (wd_cnt_q == CntLast);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            wd_cnt_q    <= '0;
            asi_valid_q <= 1'b0;
            asi_uop_q   <= '0;
            asi_rs1_q   <= '0;
            asi_rs2_q   <= '0;
            asi_shamt_q <= '0;
            asi_flush_q <= 1'b0;
            rdy0_q      <= 1'b0;
            rdy1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            res0_q      <= '0;
            res1_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        owner_q     <= gnt_sel;
                        asi_uop_q   <= gnt_uop;
                        asi_rs1_q   <= gnt_rs1;
                        asi_rs2_q   <= gnt_rs2;
                        asi_shamt_q <= gnt_shamt;
                        wd_cnt_q    <= '0;
                        asi_valid_q <= 1'b1;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                    // A completion in the same cycle as the timeout takes priority.
                    if (bus.asi_ready) begin
                        if (owner_q) begin
                            res1_q <= bus.asi_result;
                            err1_q <= 1'b0;
                            rdy1_q <= 1'b1;
                        end else begin
                            res0_q <= bus.asi_result;
                            err0_q <= 1'b0;
                            rdy0_q <= 1'b1;
                        end
                        asi_valid_q <= 1'b0;
                        state_q     <= StResp;
                    end else if (wd_fire) begin
                        if (owner_q) begin
                            res1_q <= '0;
                            err1_q <= 1'b1;
                            rdy1_q <= 1'b1;
                        end else begin
                            res0_q <= '0;
                            err0_q <= 1'b1;
                            rdy0_q <= 1'b1;
                        end
                        asi_flush_q <= 1'b1;
                        asi_valid_q <= 1'b0;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    rdy0_q      <= 1'b0;
                    rdy1_q      <= 1'b0;
                    asi_flush_q <= 1'b0;
                    last_q      <= owner_q;
                    state_q     <= StIdle;
                end
                default: begin
                    asi_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.asi_valid   = asi_valid_q;
    assign bus.asi_uop     = asi_uop_q;
    assign bus.asi_rs1     = asi_rs1_q;
    assign bus.asi_rs2     = asi_rs2_q;
    assign bus.asi_shamt   = asi_shamt_q;
    assign bus.asi_flush   = asi_flush_q;
    assign bus.req0_ready  = rdy0_q;
    assign bus.req0_result = res0_q;
    assign bus.req0_error  = err0_q;
    assign bus.req1_ready  = rdy1_q;
    assign bus.req1_result = res1_q;
    assign bus.req1_error  = err1_q;

endmodule
